// File: rtl/pic_ctrl.sv
// pic_ctrl - 8-line programmable interrupt controller for the K86 SoC.
//
// Latches one-cycle request pulses into IRR, masks them with IMR, picks the
// highest-priority (lowest-index) unmasked request and delivers its vector
// to the core by toggling irq. Lines being serviced are tracked in ISR so a
// lower-priority request cannot interrupt a higher one (nesting), and a
// holdoff counter spaces consecutive irq toggles.
//
// Ports:
//   clock     - system clock (clock_25 domain)
//   reset_n   - asynchronous active-low reset
//   irq_req   - request pulses, bit n = line n
//   port_a    - I/O port address from core
//   port_w    - I/O write strobe (one cycle)
//   port_r    - I/O read strobe (one cycle)
//   port_o    - I/O write data
//   port_i    - registered I/O read data
//   port_hit  - one-cycle pulse after a read addressed to BASE or BASE+1
//   irq       - toggle to core, each edge is one interrupt
//   irq_in    - vector, valid from the toggle until the next toggle
module pic_ctrl #(
  parameter logic [15:0] BASE      = 16'h0020,
  parameter logic [7:0]  VECT_BASE = 8'h08,
  parameter int          HOLDOFF   = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  irq_req,
  input  logic [15:0] port_a,
  input  logic        port_w,
  input  logic        port_r,
  input  logic [7:0]  port_o,
  output logic [7:0]  port_i,
  output logic        port_hit,
  output logic        irq,
  output logic [7:0]  irq_in
);

  localparam int HO_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF - 1);

  logic [7:0]      irr;
  logic [7:0]      isr;
  logic [7:0]      imr;
  logic            rsel;
  logic [HO_W-1:0] holdoff_cnt;

  logic [7:0] pend;
  logic       cand_vld;
  logic [2:0] cand_idx;
  logic       top_vld;
  logic [2:0] top_idx;
  logic       raise;
  logic [7:0] raise_set;
  logic [7:0] eoi_clr;
  logic       sel_cmd;
  logic       sel_mask;
  logic       wr_cmd;
  logic       wr_mask;
  logic       rd_hit;

  assign pend     = irr & ~imr;
  assign sel_cmd  = (port_a == BASE);
  assign sel_mask = (port_a == BASE + 16'd1);
  assign wr_cmd   = port_w && sel_cmd;
  assign wr_mask  = port_w && sel_mask;
  assign rd_hit   = port_r && (sel_cmd || sel_mask);

  // Priority encoders: scanning downward leaves the lowest set index, which
  // is the highest priority, for both the pending candidate and the
  // in-service top line.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = 3'd0;
    top_vld  = 1'b0;
    top_idx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) begin
        cand_vld = 1'b1;
        cand_idx = 3'(i);
      end
      if (isr[i]) begin
        top_vld = 1'b1;
        top_idx = 3'(i);
      end
    end
  end

  // Raise decision uses only registered state, so a same-cycle mask or EOI
  // write takes effect from the following cycle.
  always_comb begin
    raise     = cand_vld && (holdoff_cnt == '0) && (!top_vld || (cand_idx < top_idx));
    raise_set = raise ? (8'b1 << cand_idx) : 8'h00;
  end

  // EOI decode: non-specific clears the top in-service line, specific
  // (0x60..0x67) clears the named line.
  always_comb begin
    eoi_clr = 8'h00;
    if (wr_cmd) begin
      if (port_o == 8'h20) begin
        if (top_vld) eoi_clr = 8'b1 << top_idx;
      end else if (port_o[7:3] == 5'b01100) begin
        eoi_clr = 8'b1 << port_o[2:0];
      end
    end
  end

  // Controller state. The raise set is OR-ed after the EOI clear so it wins
  // on a shared ISR bit; a request arriving with the raise of the same line
  // is OR-ed after the IRR clear so it stays pending.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irr         <= 8'h00;
      isr         <= 8'h00;
      imr         <= 8'h00;
      rsel        <= 1'b0;
      holdoff_cnt <= '0;
      irq         <= 1'b0;
      irq_in      <= 8'h00;
    end else begin
      irr <= (irr & ~raise_set) | irq_req;
      isr <= (isr & ~eoi_clr) | raise_set;
      if (wr_mask) imr <= port_o;
      if (wr_cmd && port_o == 8'h0A) rsel <= 1'b0;
      if (wr_cmd && port_o == 8'h0B) rsel <= 1'b1;
      if (raise) begin
        irq         <= ~irq;
        irq_in      <= VECT_BASE + {5'b0, cand_idx};
        holdoff_cnt <= HO_LOAD;
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end
    end
  end

  // Read port: data holds between reads, hit flag pulses for one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      port_i   <= 8'h00;
      port_hit <= 1'b0;
    end else begin
      port_hit <= rd_hit;
      if (port_r && sel_cmd)  port_i <= rsel ? isr : irr;
      if (port_r && sel_mask) port_i <= imr;
    end
  end

endmodule
